// File: rtl/emu_ctrl_regfile.sv
`default_nettype none
// ============================================================================
// Module   : emu_ctrl_regfile
// Brief    : Emulator run-control register bank (run gate, stepping, cycle count).
// Revision : 1.0 - initial release
// ============================================================================
module emu_ctrl_regfile #(
  parameter logic [31:0] ID_VALUE   = 32'h52454D55,
  parameter int          STEP_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctrl_wen,
  input  logic [9:0]  ctrl_waddr,
  input  logic [31:0] ctrl_wdata,
  input  logic        ctrl_ren,
  input  logic [9:0]  ctrl_raddr,
  output logic [31:0] ctrl_rdata,
  input  logic        emu_halt_req,
  output logic        emu_run,
  output logic        emu_model_rst
);

  localparam logic [9:0] ADDR_CTRL    = 10'h000;
  localparam logic [9:0] ADDR_STEP    = 10'h001;
  localparam logic [9:0] ADDR_STATUS  = 10'h002;
  localparam logic [9:0] ADDR_CYC_LO  = 10'h004;
  localparam logic [9:0] ADDR_CYC_HI  = 10'h005;
  localparam logic [9:0] ADDR_SCRATCH = 10'h006;
  localparam logic [9:0] ADDR_ID      = 10'h007;

  localparam logic [STEP_WIDTH-1:0] STEP_ZERO = '0;
  localparam logic [STEP_WIDTH-1:0] STEP_ONE  = STEP_WIDTH'(1);

  logic                  run_q,       run_d;
  logic                  model_rst_q, model_rst_d;
  logic [STEP_WIDTH-1:0] step_q,      step_d;
  logic [63:0]           cycle_q,     cycle_d;
  logic [31:0]           shadow_q,    shadow_d;
  logic                  halted_q,    halted_d;
  logic                  step_done_q, step_done_d;
  logic [31:0]           scratch_q,   scratch_d;

  logic                  wr_ctrl, wr_step, wr_status, wr_cyc_lo, wr_scratch;
  logic                  sw_run_set, halt_fire, step_expire;
  logic [STEP_WIDTH-1:0] step_wdata;
  logic [31:0]           step_rd;

  always_comb begin
    wr_ctrl     = ctrl_wen && (ctrl_waddr == ADDR_CTRL);
    wr_step     = ctrl_wen && (ctrl_waddr == ADDR_STEP);
    wr_status   = ctrl_wen && (ctrl_waddr == ADDR_STATUS);
    wr_cyc_lo   = ctrl_wen && (ctrl_waddr == ADDR_CYC_LO);
    wr_scratch  = ctrl_wen && (ctrl_waddr == ADDR_SCRATCH);
    step_wdata  = ctrl_wdata[STEP_WIDTH-1:0];
    sw_run_set  = (wr_ctrl && ctrl_wdata[0]) || (wr_step && (step_wdata != STEP_ZERO));
    // A halt request also blocks a run that software is starting this cycle.
    halt_fire   = emu_halt_req && (run_q || sw_run_set);
    step_expire = run_q && (step_q == STEP_ONE);

    // Lowest priority first; later assignments override.
    run_d       = run_q;
    step_d      = (run_q && (step_q != STEP_ZERO)) ? (step_q - STEP_ONE) : step_q;
    model_rst_d = wr_ctrl ? ctrl_wdata[1] : model_rst_q;

    if (wr_step) begin
      step_d = step_wdata;
      if (step_wdata != STEP_ZERO) run_d = 1'b1;
    end
    if (wr_ctrl && ctrl_wdata[0]) run_d = 1'b1;
    if (step_expire) begin
      run_d  = 1'b0;
      step_d = STEP_ZERO;
    end
    if (wr_ctrl && !ctrl_wdata[0]) begin
      run_d  = 1'b0;
      step_d = STEP_ZERO;
    end
    if (halt_fire) begin
      run_d  = 1'b0;
      step_d = STEP_ZERO;
    end

    halted_d    = (halted_q    & ~(wr_status & ctrl_wdata[1])) | halt_fire;
    step_done_d = (step_done_q & ~(wr_status & ctrl_wdata[2])) | step_expire;

    if (wr_cyc_lo)  cycle_d = 64'd0;
    else if (run_q) cycle_d = cycle_q + 64'd1;
    else            cycle_d = cycle_q;

    shadow_d  = (ctrl_ren && (ctrl_raddr == ADDR_CYC_LO)) ? cycle_q[63:32] : shadow_q;
    scratch_d = wr_scratch ? ctrl_wdata : scratch_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      model_rst_q <= 1'b1;
      step_q      <= STEP_ZERO;
      cycle_q     <= 64'd0;
      shadow_q    <= 32'd0;
      halted_q    <= 1'b0;
      step_done_q <= 1'b0;
      scratch_q   <= 32'd0;
    end else begin
      run_q       <= run_d;
      model_rst_q <= model_rst_d;
      step_q      <= step_d;
      cycle_q     <= cycle_d;
      shadow_q    <= shadow_d;
      halted_q    <= halted_d;
      step_done_q <= step_done_d;
      scratch_q   <= scratch_d;
    end
  end

  always_comb begin
    step_rd                 = 32'd0;
    step_rd[STEP_WIDTH-1:0] = step_q;
  end

  // Read data reflects current (pre-update) state.
  always_comb begin
    ctrl_rdata = 32'd0;
    case (ctrl_raddr)
      ADDR_CTRL:    ctrl_rdata = {30'd0, model_rst_q, run_q};
      ADDR_STEP:    ctrl_rdata = step_rd;
      ADDR_STATUS:  ctrl_rdata = {29'd0, step_done_q, halted_q, run_q};
      ADDR_CYC_LO:  ctrl_rdata = cycle_q[31:0];
      ADDR_CYC_HI:  ctrl_rdata = shadow_q;
      ADDR_SCRATCH: ctrl_rdata = scratch_q;
      ADDR_ID:      ctrl_rdata = ID_VALUE;
      default:      ctrl_rdata = 32'd0;
    endcase
  end

  assign emu_run       = run_q;
  assign emu_model_rst = model_rst_q;

endmodule
`default_nettype wire

// File: tb/tb_emu_ctrl_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_emu_ctrl_regfile
// Brief    : Directed vector bench for emu_ctrl_regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_emu_ctrl_regfile;

  logic        clk;
  logic        rst_n;
  logic        ctrl_wen;
  logic [9:0]  ctrl_waddr;
  logic [31:0] ctrl_wdata;
  logic        ctrl_ren;
  logic [9:0]  ctrl_raddr;
  logic [31:0] ctrl_rdata;
  logic        emu_halt_req;
  logic        emu_run;
  logic        emu_model_rst;

  int checks = 0;
  int errors = 0;

  emu_ctrl_regfile dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ctrl_wen      (ctrl_wen),
    .ctrl_waddr    (ctrl_waddr),
    .ctrl_wdata    (ctrl_wdata),
    .ctrl_ren      (ctrl_ren),
    .ctrl_raddr    (ctrl_raddr),
    .ctrl_rdata    (ctrl_rdata),
    .emu_halt_req  (emu_halt_req),
    .emu_run       (emu_run),
    .emu_model_rst (emu_model_rst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          is_wr;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Each bus task starts at a negedge and returns at the next negedge.
  task automatic wr(input logic [9:0] addr, input logic [31:0] data);
    ctrl_wen   = 1'b1;
    ctrl_waddr = addr;
    ctrl_wdata = data;
    @(negedge clk);
    ctrl_wen   = 1'b0;
  endtask

  task automatic rd(input logic [9:0] addr, input logic [31:0] exp, input string name);
    ctrl_ren   = 1'b1;
    ctrl_raddr = addr;
    #1;
    chk(name, {32'd0, ctrl_rdata}, {32'd0, exp});
    @(negedge clk);
    ctrl_ren   = 1'b0;
  endtask

  task automatic count_run(output int n);
    n = 0;
    while (emu_run && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n        = 1'b0;
    ctrl_wen     = 1'b0;
    ctrl_waddr   = '0;
    ctrl_wdata   = '0;
    ctrl_ren     = 1'b0;
    ctrl_raddr   = '0;
    emu_halt_req = 1'b0;

    vecs[0]  = '{1'b0, 10'h000, 32'h0,        32'h0000_0002};
    vecs[1]  = '{1'b0, 10'h007, 32'h0,        32'h5245_4D55};
    vecs[2]  = '{1'b0, 10'h3FF, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 10'h006, 32'h0,        32'h0};
    vecs[4]  = '{1'b1, 10'h006, 32'hDEAD_BEEF, 32'h0};
    vecs[5]  = '{1'b0, 10'h006, 32'h0,        32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, 10'h3FF, 32'h0000_1234, 32'h0};
    vecs[7]  = '{1'b0, 10'h3FF, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 10'h007, 32'h0,        32'h0};
    vecs[9]  = '{1'b0, 10'h007, 32'h0,        32'h5245_4D55};
    vecs[10] = '{1'b1, 10'h000, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 10'h000, 32'h0,        32'h0};
    vecs[12] = '{1'b0, 10'h002, 32'h0,        32'h0};
    vecs[13] = '{1'b0, 10'h001, 32'h0,        32'h0};
    vecs[14] = '{1'b1, 10'h003, 32'hFFFF_FFFF, 32'h0};
    vecs[15] = '{1'b0, 10'h003, 32'h0,        32'h0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_run", {63'd0, emu_run}, 64'd0);
    chk("reset_model_rst", {63'd0, emu_model_rst}, 64'd1);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data);
      else rd(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
    end
    chk("model_rst_cleared", {63'd0, emu_model_rst}, 64'd0);
    rd(10'h004, 32'd0, "cyc_lo_init");
    rd(10'h005, 32'd0, "cyc_hi_init");

    // Free run for exactly 10 cycles.
    wr(10'h000, 32'h1);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("run_hi_%0d", i), {63'd0, emu_run}, 64'd1);
      @(negedge clk);
    end
    chk("run_hi_9", {63'd0, emu_run}, 64'd1);
    wr(10'h000, 32'h0);
    chk("run_stopped", {63'd0, emu_run}, 64'd0);
    rd(10'h004, 32'd10, "run10_lo");
    rd(10'h005, 32'd0, "run10_hi");

    // Step 5.
    wr(10'h004, 32'h0);
    rd(10'h004, 32'd0, "cyc_cleared");
    wr(10'h001, 32'd5);
    count_run(n);
    chk("step5_cycles", n, 64'd5);
    rd(10'h002, 32'h4, "step_status");
    rd(10'h001, 32'h0, "step_readback");
    rd(10'h004, 32'd5, "step_cycle_lo");
    wr(10'h002, 32'h4);
    rd(10'h002, 32'h0, "step_w1c");

    // Halt on the 3rd run cycle.
    wr(10'h004, 32'h0);
    wr(10'h000, 32'h1);
    repeat (2) @(negedge clk);
    emu_halt_req = 1'b1;
    @(negedge clk);
    emu_halt_req = 1'b0;
    chk("halt_run_low", {63'd0, emu_run}, 64'd0);
    rd(10'h004, 32'd3, "halt_cycle_lo");
    rd(10'h002, 32'h2, "halt_status");
    wr(10'h002, 32'h2);
    rd(10'h002, 32'h0, "halt_w1c");

    // 32-bit carry into the high word and shadow latching.
    force dut.cycle_q = 64'h0000_0001_FFFF_FFFF;
    @(negedge clk);
    release dut.cycle_q;
    wr(10'h000, 32'h1);
    wr(10'h000, 32'h0);
    chk("carry_run_low", {63'd0, emu_run}, 64'd0);
    rd(10'h004, 32'd0, "carry_lo");
    rd(10'h005, 32'd2, "carry_hi");
    wr(10'h000, 32'h1);
    wr(10'h000, 32'h0);
    rd(10'h005, 32'd2, "shadow_hold_hi");
    rd(10'h004, 32'd1, "after_carry_lo");

    // Halt request coinciding with a software run start.
    emu_halt_req = 1'b1;
    wr(10'h000, 32'h1);
    emu_halt_req = 1'b0;
    chk("halt_vs_start_run", {63'd0, emu_run}, 64'd0);
    rd(10'h002, 32'h2, "halt_vs_start_status");
    wr(10'h002, 32'h2);

    // Reset in the middle of a step sequence.
    wr(10'h006, 32'h0000_00AB);
    wr(10'h001, 32'd20);
    repeat (3) @(negedge clk);
    chk("midstep_running", {63'd0, emu_run}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_run", {63'd0, emu_run}, 64'd0);
    chk("rst_model_rst", {63'd0, emu_model_rst}, 64'd1);
    rd(10'h005, 32'd0, "rst_shadow");
    rd(10'h001, 32'd0, "rst_step");
    rd(10'h006, 32'd0, "rst_scratch");
    rd(10'h002, 32'd0, "rst_status");
    rd(10'h004, 32'd0, "rst_cycle_lo");
    chk("rst_stays_idle", {63'd0, emu_run}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
